// File: rtl/dreq_arbiter_if.sv
// Bundle of the request/acknowledge signals between the peripherals, the
// DMA request arbiter and the DMAC.
//   REQ   : per-peripheral request level, bit i = channel i
//   MODE  : 0 = fixed priority, 1 = rotating priority
//   DREQ  : request presented to the DMAC
//   DACK  : acknowledge from the DMAC
//   EOP   : end-of-process from the DMAC
//   ACK   : per-peripheral acknowledge, one-hot or zero
//   CHSEL : index of the granted channel
//   BUSY  : arbiter not idle
//   ERR   : one-cycle DACK timeout pulse
// Modport slave is the arbiter side; master is the environment side.
interface dreq_arbiter_if #(
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = 2
);
  logic [NCH-1:0] REQ;
  logic           MODE;
  logic           DREQ;
  logic           DACK;
  logic           EOP;
  logic [NCH-1:0] ACK;
  logic [CW-1:0]  CHSEL;
  logic           BUSY;
  logic           ERR;

  modport master (
    output REQ, MODE, DACK, EOP,
    input  DREQ, ACK, CHSEL, BUSY, ERR
  );

  modport slave (
    input  REQ, MODE, DACK, EOP,
    output DREQ, ACK, CHSEL, BUSY, ERR
  );
endinterface

// File: rtl/dreq_arbiter.sv
// Multi-channel DMA request arbiter placed in front of the DMAC. Picks one
// requesting peripheral (fixed or rotating priority), raises DREQ, routes the
// DMAC's DACK back to that peripheral only, and holds the grant until EOP.
// Ports:
//   CLK : system clock, rising edge
//   RST : asynchronous active-low reset
//   bus : dreq_arbiter_if.slave (REQ, MODE, DACK, EOP in; DREQ, ACK, CHSEL,
//         BUSY, ERR out, all outputs registered)
// Optional build macro ARB_TIMEOUT_EN: adds a GRANT-state DACK timeout of
// TIMEOUT_CYC cycles that pulses ERR, drops DREQ and skips the stalled
// channel. Without it GRANT waits indefinitely and ERR is tied low.
module dreq_arbiter #(
  parameter int unsigned NCH         = 4,
  parameter int unsigned CW          = 2,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input logic           CLK,
  input logic           RST,
  dreq_arbiter_if.slave bus
);

  // Elaboration-time parameter sanity check
  if (NCH < 2 || NCH > 8 || (2 ** CW) < NCH || TIMEOUT_CYC < 1) begin : g_param_check
    $error("dreq_arbiter: illegal NCH/CW/TIMEOUT_CYC combination");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    ACTIVE  = 2'd2,
    RELEASE = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  chsel_q, chsel_d;
  logic [CW-1:0]  ptr_q, ptr_d;
  logic           dreq_q, dreq_d;
  logic [NCH-1:0] ack_q, ack_d;
  logic           busy_q;
  logic [CW-1:0]  winner;
  logic [CW-1:0]  chsel_inc;
  logic           req_sel;
  logic           timeout;

  // Decode a channel index into an NCH-wide one-hot vector
  function automatic logic [NCH-1:0] onehot(input logic [CW-1:0] idx);
    logic [NCH-1:0] v;
    v = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      if (idx == CW'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  // First set request bit, scanning up from 0 (fixed) or from ptr (rotating)
  function automatic logic [CW-1:0] pick(input logic [NCH-1:0] req,
                                         input logic           rot,
                                         input logic [CW-1:0]  ptr);
    logic [CW-1:0]  w;
    logic           found;
    logic [NCH-1:0] sh;
    int unsigned    idx;
    w     = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NCH; k++) begin
      idx = rot ? ((32'(ptr) + k) % NCH) : k;
      sh  = req >> idx;
      if (!found && sh[0]) begin
        found = 1'b1;
        w     = CW'(idx);
      end
    end
    return w;
  endfunction

  assign winner    = pick(bus.REQ, bus.MODE, ptr_q);
  assign req_sel   = |(bus.REQ & onehot(chsel_q));
  assign chsel_inc = (chsel_q == CW'(NCH - 1)) ? '0 : chsel_q + CW'(1);

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

  logic [CNT_W-1:0] cnt_q;
  logic             err_d, err_q;

  // Cycles spent waiting in GRANT; cleared whenever GRANT is left or entered
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= '0;
    end else if (state_q == GRANT && state_d == GRANT) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else begin
      cnt_q <= '0;
    end
  end

  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // ERR fires only when the timeout is the event that actually ends GRANT
  assign err_d = (state_q == GRANT) && !bus.EOP && !bus.DACK && req_sel && timeout;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.ERR = err_q;
`else
  assign timeout = 1'b0;
  assign bus.ERR = 1'b0;
`endif

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; EOP outranks DACK, DACK outranks withdrawal/timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (|bus.REQ) state_d = GRANT;
      end
      GRANT: begin
        if (bus.EOP)       state_d = RELEASE;
        else if (bus.DACK) state_d = ACTIVE;
        else if (!req_sel) state_d = IDLE;
        else if (timeout)  state_d = IDLE;
      end
      ACTIVE: begin
        if (bus.EOP) state_d = RELEASE;
      end
      RELEASE: begin
        if (!bus.DACK) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and the rotate pointer
  always_comb begin
    dreq_d  = 1'b0;
    ack_d   = '0;
    chsel_d = chsel_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (|bus.REQ) begin
          chsel_d = winner;
          dreq_d  = 1'b1;
        end
      end
      GRANT: begin
        if (bus.EOP) begin
          dreq_d = 1'b0;
        end else if (bus.DACK) begin
          dreq_d = req_sel;
        end else if (!req_sel) begin
          // Withdrawal: pointer deliberately left alone
          dreq_d = 1'b0;
        end else if (timeout) begin
          dreq_d = 1'b0;
          ptr_d  = chsel_inc;
        end else begin
          dreq_d = 1'b1;
        end
      end
      ACTIVE: begin
        if (!bus.EOP) begin
          dreq_d = req_sel;
          ack_d  = bus.DACK ? onehot(chsel_q) : '0;
        end
      end
      RELEASE: begin
        if (!bus.DACK) ptr_d = chsel_inc;
      end
      default: begin
        dreq_d = 1'b0;
      end
    endcase
  end

  // Output and pointer registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      dreq_q  <= 1'b0;
      ack_q   <= '0;
      chsel_q <= '0;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      dreq_q  <= dreq_d;
      ack_q   <= ack_d;
      chsel_q <= chsel_d;
      ptr_q   <= ptr_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign bus.DREQ  = dreq_q;
  assign bus.ACK   = ack_q;
  assign bus.CHSEL = chsel_q;
  assign bus.BUSY  = busy_q;

endmodule

// File: tb/tb_dreq_arbiter.sv
// Self-checking bench for dreq_arbiter (NCH=4, CW=2). A table of per-cycle
// input/expected-output vectors covers reset, fixed and rotating priority,
// withdrawal, simultaneous EOP/DACK and REQ changes during a transfer; hand
// sequences cover GRANT waiting (or the ARB_TIMEOUT_EN timeout) and an
// asynchronous reset in the middle of a transfer.
module tb_dreq_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TO = 8;
`else
  localparam int unsigned TO = 64;
`endif

  logic CLK;
  logic RST;
  int   errors;
  int   checks;

  dreq_arbiter_if #(.NCH(4), .CW(2)) bus ();

  dreq_arbiter #(.NCH(4), .CW(2), .TIMEOUT_CYC(TO)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string      name;
    logic       rst;
    logic [3:0] req;
    logic       mode;
    logic       dack;
    logic       eop;
    logic       dreq;
    logic [3:0] ack;
    logic [1:0] chsel;
    logic       busy;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input logic r, input logic [3:0] q,
                     input logic m, input logic d, input logic e,
                     input logic x_dreq, input logic [3:0] x_ack,
                     input logic [1:0] x_chsel, input logic x_busy, input logic x_err);
    vec_t v;
    v.name = n;  v.rst = r;  v.req = q;  v.mode = m;  v.dack = d;  v.eop = e;
    v.dreq = x_dreq;  v.ack = x_ack;  v.chsel = x_chsel;
    v.busy = x_busy;  v.err = x_err;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [3:0] q, input logic m, input logic d, input logic e);
    bus.REQ  = q;
    bus.MODE = m;
    bus.DACK = d;
    bus.EOP  = e;
  endtask

  // Compare {DREQ, ACK, CHSEL, BUSY, ERR} against the expected packed value
  task automatic check(input string n, input logic x_dreq, input logic [3:0] x_ack,
                       input logic [1:0] x_chsel, input logic x_busy, input logic x_err);
    logic [8:0] got;
    logic [8:0] exp;
    got = {bus.DREQ, bus.ACK, bus.CHSEL, bus.BUSY, bus.ERR};
    exp = {x_dreq, x_ack, x_chsel, x_busy, x_err};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got dreq/ack/chsel/busy/err=%b expected %b at %0t", n, got, exp, $time);
    end
  endtask

  logic [1:0] rot_seq [5];

  initial begin
    errors = 0;
    checks = 0;
    RST    = 1'b0;
    drive(4'h0, 1'b0, 1'b0, 1'b0);
    rot_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    //   name           rst req   mode dack eop   dreq ack   chsel busy err
    add("rst_hold0",    0, 4'hF, 0, 0, 0,    0, 4'h0, 2'd0, 0, 0);
    add("rst_hold1",    0, 4'hF, 0, 0, 0,    0, 4'h0, 2'd0, 0, 0);
    add("rst_release",  1, 4'hF, 0, 0, 0,    1, 4'h0, 2'd0, 1, 0);
    add("first_wd",     1, 4'h0, 0, 0, 0,    0, 4'h0, 2'd0, 0, 0);
    add("fx_grant",     1, 4'hA, 0, 0, 0,    1, 4'h0, 2'd1, 1, 0);
    add("fx_dack",      1, 4'hA, 0, 1, 0,    1, 4'h0, 2'd1, 1, 0);
    add("fx_ack",       1, 4'hA, 0, 1, 0,    1, 4'h2, 2'd1, 1, 0);
    add("fx_eop",       1, 4'hA, 0, 1, 1,    0, 4'h0, 2'd1, 1, 0);
    add("fx_rel_wait",  1, 4'hA, 0, 1, 0,    0, 4'h0, 2'd1, 1, 0);
    add("fx_rel_idle",  1, 4'hA, 0, 0, 0,    0, 4'h0, 2'd1, 0, 0);
    add("idle_eop",     1, 4'h0, 0, 0, 1,    0, 4'h0, 2'd1, 0, 0);
    add("fx_ignore_ptr",1, 4'hF, 0, 0, 0,    1, 4'h0, 2'd0, 1, 0);
    add("fx_wd",        1, 4'h0, 0, 0, 0,    0, 4'h0, 2'd0, 0, 0);
    add("rst_again",    0, 4'h0, 0, 0, 0,    0, 4'h0, 2'd0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      add("rot_grant",  1, 4'hF, 1, 0, 0,    1, 4'h0, rot_seq[k], 1, 0);
      add("rot_dack",   1, 4'hF, 1, 1, 0,    1, 4'h0, rot_seq[k], 1, 0);
      add("rot_ack",    1, 4'hF, 1, 1, 0,    1, 4'(4'h1 << rot_seq[k]), rot_seq[k], 1, 0);
      add("rot_eop",    1, 4'hF, 1, 1, 1,    0, 4'h0, rot_seq[k], 1, 0);
      add("rot_idle",   1, 4'hF, 1, 0, 0,    0, 4'h0, rot_seq[k], 0, 0);
    end
    // pointer is now 1
    add("wd_grant",     1, 4'h4, 1, 0, 0,    1, 4'h0, 2'd2, 1, 0);
    add("wd_drop",      1, 4'h0, 1, 0, 0,    0, 4'h0, 2'd2, 0, 0);
    add("wd_ptr_kept",  1, 4'hC, 1, 0, 0,    1, 4'h0, 2'd2, 1, 0);
    add("wd_drop2",     1, 4'h0, 1, 0, 0,    0, 4'h0, 2'd2, 0, 0);
    add("sim_grant",    1, 4'h8, 1, 0, 0,    1, 4'h0, 2'd3, 1, 0);
    add("sim_both",     1, 4'h8, 1, 1, 1,    0, 4'h0, 2'd3, 1, 0);
    add("sim_rel_wait", 1, 4'h8, 1, 1, 0,    0, 4'h0, 2'd3, 1, 0);
    add("sim_idle",     1, 4'h0, 1, 0, 0,    0, 4'h0, 2'd3, 0, 0);
    add("chg_grant",    1, 4'h2, 0, 0, 0,    1, 4'h0, 2'd1, 1, 0);
    add("chg_dack",     1, 4'h3, 0, 1, 0,    1, 4'h0, 2'd1, 1, 0);
    add("chg_req_drop", 1, 4'h1, 0, 1, 0,    0, 4'h2, 2'd1, 1, 0);
    add("chg_nodack",   1, 4'h1, 0, 0, 0,    0, 4'h0, 2'd1, 1, 0);
    add("chg_eop",      1, 4'h1, 0, 0, 1,    0, 4'h0, 2'd1, 1, 0);
    add("chg_idle",     1, 4'h1, 0, 0, 0,    0, 4'h0, 2'd1, 0, 0);

    #2;
    foreach (vecs[i]) begin
      RST = vecs[i].rst;
      drive(vecs[i].req, vecs[i].mode, vecs[i].dack, vecs[i].eop);
      tick();
      check(vecs[i].name, vecs[i].dreq, vecs[i].ack, vecs[i].chsel, vecs[i].busy, vecs[i].err);
    end

    // Long DACK wait in GRANT on channel 0
    drive(4'h1, 1'b1, 1'b0, 1'b0);
    tick();
    check("to_grant", 1, 4'h0, 2'd0, 1, 0);
`ifdef ARB_TIMEOUT_EN
    for (int i = 1; i < 8; i++) begin
      tick();
      check("to_wait", 1, 4'h0, 2'd0, 1, 0);
    end
    tick();
    check("to_err", 0, 4'h0, 2'd0, 0, 1);
    drive(4'h3, 1'b1, 1'b0, 1'b0);
    tick();
    check("to_next", 1, 4'h0, 2'd1, 1, 0);
    drive(4'h0, 1'b1, 1'b0, 1'b0);
    tick();
    check("to_wd", 0, 4'h0, 2'd1, 0, 0);
`else
    for (int i = 0; i < 80; i++) begin
      tick();
      check("grant_hold", 1, 4'h0, 2'd0, 1, 0);
    end
    drive(4'h0, 1'b1, 1'b0, 1'b0);
    tick();
    check("grant_hold_wd", 0, 4'h0, 2'd0, 0, 0);
`endif

    // Asynchronous reset in the middle of an active transfer
    drive(4'h2, 1'b0, 1'b0, 1'b0);
    tick();
    check("ar_grant", 1, 4'h0, 2'd1, 1, 0);
    drive(4'h2, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    check("ar_ack", 1, 4'h2, 2'd1, 1, 0);
    #3;
    RST = 1'b0;
    #1;
    check("ar_async", 0, 4'h0, 2'd0, 0, 0);
    drive(4'h9, 1'b1, 1'b0, 1'b0);
    tick();
    check("ar_hold", 0, 4'h0, 2'd0, 0, 0);
    RST = 1'b1;
    tick();
    check("ar_restart_ptr0", 1, 4'h0, 2'd0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dreq_arbiter.md
Name: dreq_arbiter

Overview:
- Multi-channel DMA request arbiter that sits directly upstream of the DMAC.
- Collects per-peripheral requests and presents a single DREQ to the DMAC.
- Tells the DMAC-side logic which channel won via CHSEL.
- Routes the DMAC's DACK back to the winning peripheral only.
- Holds the grant until the DMAC signals EOP, then re-arbitrates using fixed or rotating priority.

Parameters:
- NCH, 4, number of request channels (2..8).
- CW, 2, width of CHSEL; must satisfy 2^CW >= NCH.
- TIMEOUT_CYC, 64, DACK wait limit in cycles (used only with ARB_TIMEOUT_EN).

Ports:
- CLK  input  1  system clock, all state on rising edge.
- RST  input  1  asynchronous, active-low reset (RST=0 resets immediately).
- REQ  input  NCH  per-peripheral request, level, bit i = channel i.
- MODE  input  1  0 = fixed priority (channel 0 highest), 1 = rotating priority.
- DREQ  output  1  request to the DMAC.
- DACK  input  1  acknowledge from the DMAC.
- EOP  input  1  end-of-process from the DMAC.
- ACK  output  NCH  per-peripheral acknowledge, one-hot or zero.
- CHSEL  output  CW  index of the granted channel.
- BUSY  output  1  high whenever the state is not IDLE.
- ERR  output  1  one-cycle timeout pulse; constant 0 unless ARB_TIMEOUT_EN.

Behaviour:
- Reset (RST=0, async): state=IDLE, DREQ=0, ACK=0, CHSEL=0, BUSY=0, ERR=0, rotate pointer PTR=0. All outputs are registered.
- State IDLE:
  - REQ is sampled each edge.
  - If REQ!=0, the winner is latched into CHSEL on that edge and the state moves to GRANT.
  - DREQ rises on that same edge, so there is 1 cycle of latency from REQ to DREQ.
- Winner selection:
  - MODE=0: lowest set index wins.
  - MODE=1: first set bit scanning upward from PTR, wrapping at NCH-1 to 0.
  - MODE is sampled only in IDLE.
- State GRANT:
  - DREQ=1, ACK=0.
  - On DACK=1, go to ACTIVE.
  - If REQ[CHSEL] drops before DACK (withdrawal), go to IDLE, clear DREQ, leave PTR unchanged.
- State ACTIVE:
  - DREQ=1 while REQ[CHSEL]=1.
  - ACK[CHSEL] follows the registered DACK (1 cycle delay); all other ACK bits stay 0.
  - On EOP=1, go to RELEASE and clear DREQ and ACK on the same edge.
- State RELEASE:
  - DREQ=0, ACK=0.
  - Wait for DACK=0, then go to IDLE.
  - On that edge, PTR = CHSEL+1, wrapping to 0 after NCH-1. PTR updates in both modes but is used only when MODE=1.
- Simultaneous events:
  - EOP and DACK together in GRANT: EOP wins, go to RELEASE.
  - EOP in IDLE is ignored.
  - New REQ bits during GRANT, ACTIVE or RELEASE are ignored until IDLE; there is no preemption.
- REQ=0 in IDLE: remain idle, no output change.
- Reset asserted mid-transfer: all outputs drop asynchronously. After reset release the block restarts in IDLE with PTR=0.
- CHSEL holds its value through RELEASE and changes only at the next grant.

Optional Feature:
- ARB_TIMEOUT_EN defined:
  - An 8-bit-or-wider counter runs in GRANT.
  - If DACK is not seen within TIMEOUT_CYC cycles, the block pulses ERR=1 for one cycle and drops DREQ.
  - It then goes to IDLE and advances PTR past the stalled channel.
  - The counter clears on leaving GRANT.
- ARB_TIMEOUT_EN not defined: no counter is built, GRANT waits indefinitely, ERR is tied to 0.

Test Plan:
- Reset: RST=0 with REQ=4'b1111 -> DREQ=0, ACK=0, CHSEL=0, BUSY=0. After release, DREQ=1 and CHSEL=0 one edge later.
- Fixed priority, full handshake: MODE=0, REQ=4'b1010.
  - CHSEL=1, DREQ=1 after 1 cycle.
  - DACK=1 -> ACK=4'b0010 one cycle later.
  - EOP=1 -> DREQ=0, ACK=0; BUSY=0 once DACK=0.
- Rotating priority: MODE=1, REQ=4'b1111 held, DACK/EOP handshake repeated 5 times -> CHSEL sequence 0,1,2,3,0.
- Withdrawal: REQ=4'b0100, REQ drops to 0 in GRANT before DACK -> DREQ=0 next edge, state IDLE. Next REQ=4'b1100 with MODE=1 -> CHSEL=2 (PTR unchanged).
- Simultaneous EOP and DACK in GRANT -> RELEASE; ACK never asserts. A REQ change during ACTIVE does not alter CHSEL.
- ARB_TIMEOUT_EN with TIMEOUT_CYC=8, REQ=4'b0001, DACK held 0:
  - ERR pulses once, 8 cycles after DREQ rises; DREQ=0.
  - Next grant with REQ=4'b0011 and MODE=1 -> CHSEL=1.
